// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the PC, issues credit-limited fetches to a
// variable-latency memory, and queues returned instructions in order for decode.
module fetch_unit #(
    parameter int unsigned        XLEN     = 64,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [XLEN-1:0]    RESET_PC = '0
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            redirect_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic            imem_req_valid_o,
    output logic [XLEN-1:0] imem_req_addr_o,
    input  logic            imem_req_ready_i,
    input  logic            imem_rsp_valid_i,
    input  logic [31:0]     imem_rsp_data_i,
    output logic            id_valid_o,
    output logic [31:0]     id_instr_o,
    output logic [XLEN-1:0] id_pc_o,
    input  logic            id_ready_i
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

    // Architectural state
    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   infl_q, infl_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   tag_rd_q, tag_rd_d;
    logic [PW-1:0]   tag_wr_q, tag_wr_d;

    // Decode queue and in-flight request PC tags (data only, no reset needed)
    logic [31:0]     q_instr_q [DEPTH];
    logic [XLEN-1:0] q_pc_q    [DEPTH];
    logic [XLEN-1:0] tag_pc_q  [DEPTH];

    logic            req_fire;
    logic            rsp_take;
    logic            pop;
    logic            push;
    logic            tag_push;
    logic [CW:0]     occupancy;

    // Credit: queued plus outstanding fetches never exceed the queue size
    assign occupancy        = {1'b0, count_q} + {1'b0, infl_q};
    assign imem_req_valid_o = !rst_i && !redirect_i && (occupancy < DEPTH_W);
    assign imem_req_addr_o  = pc_q;

    assign id_valid_o = (count_q != '0) && !redirect_i;
    assign id_instr_o = (count_q != '0) ? q_instr_q[rd_q] : 32'h0;
    assign id_pc_o    = (count_q != '0) ? q_pc_q[rd_q]    : '0;

    assign req_fire = imem_req_valid_o && imem_req_ready_i;
    assign rsp_take = imem_rsp_valid_i && (infl_q != '0);
    assign pop      = id_valid_o && id_ready_i;

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        infl_d   = infl_q;
        drop_d   = drop_q;
        rd_d     = rd_q;
        wr_d     = wr_q;
        tag_rd_d = tag_rd_q;
        tag_wr_d = tag_wr_q;
        push     = 1'b0;
        tag_push = 1'b0;

        if (rsp_take) begin
            tag_rd_d = tag_rd_q + PW'(1);
        end

        if (redirect_i) begin
            // Flush: every request still outstanding after this cycle is stale
            pc_d    = redirect_pc_i;
            count_d = '0;
            rd_d    = '0;
            wr_d    = '0;
            infl_d  = infl_q - CW'(rsp_take);
            drop_d  = infl_q - CW'(rsp_take);
        end else begin
            if (req_fire) begin
                pc_d     = pc_q + XLEN'(4);
                tag_wr_d = tag_wr_q + PW'(1);
                tag_push = 1'b1;
            end
            if (rsp_take) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - CW'(1);
                end else begin
                    push = 1'b1;
                    wr_d = wr_q + PW'(1);
                end
            end
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            infl_d  = infl_q + CW'(req_fire) - CW'(rsp_take);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            infl_q   <= '0;
            drop_q   <= '0;
            rd_q     <= '0;
            wr_q     <= '0;
            tag_rd_q <= '0;
            tag_wr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            infl_q   <= infl_d;
            drop_q   <= drop_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            tag_rd_q <= tag_rd_d;
            tag_wr_q <= tag_wr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            q_instr_q[wr_q] <= imem_rsp_data_i;
            q_pc_q[wr_q]    <= tag_pc_q[tag_rd_q];
        end
        if (tag_push) begin
            tag_pc_q[tag_wr_q] <= pc_q;
        end
    end

endmodule
